// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite widths, response encodings and the write-beat payload layout
// used by the AXI4-Lite to core-memory bridge.
package axi4l_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } w_beat_t;

    function automatic axi_resp_e resp_from_err(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4l2core_if.sv
// Bus bundles for the bridge: the AXI4-Lite slave side and the core-style
// request/grant memory side.
interface axi4l_if;
    import axi4l_pkg::*;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

interface core_mem_if;
    import axi4l_pkg::*;

    logic              req;
    logic              we;
    logic [STRB_W-1:0] be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/axi4l_hold_slot.sv
// One-entry holding register for a single AXI channel: accepts a beat when empty,
// keeps it until the owner clears it.
module axi4l_hold_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] payload_i,
    input  logic             clear_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [WIDTH-1:0] payload_o
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] payload_q;
    logic [WIDTH-1:0] payload_d;
    logic             load;

    // Ready is gated by reset so the channel never handshakes while held in reset.
    assign ready_o = rst_n && !full_q;
    assign load    = valid_i && ready_o;

    always_comb begin
        full_d    = full_q;
        payload_d = payload_q;
        if (load) begin
            full_d    = 1'b1;
            payload_d = payload_i;
        end else if (clear_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            payload_q <= '0;
        end else begin
            full_q    <= full_d;
            payload_q <= payload_d;
        end
    end

    assign full_o    = full_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/axi4l2core.sv
// AXI4-Lite slave to core-style memory bridge: buffers AW/W/AR in one-entry slots
// and runs one memory transaction at a time through a four-state FSM.
module axi4l2core
    import axi4l_pkg::*;
#(
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    axi4l_if.slave     axi,
    core_mem_if.master mem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q;
    logic              is_write_q;
    logic              req_q;
    logic              err_q;
    logic              bvalid_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              aw_full;
    logic              w_full;
    logic              ar_full;
    logic [ADDR_W-1:0] aw_addr;
    logic [ADDR_W-1:0] ar_addr;
    w_beat_t           w_beat;
    w_beat_t           w_beat_in;
    logic              grant_fire;
    logic              aw_clr;
    logic              w_clr;
    logic              ar_clr;
    logic              wr_cand;
    logic              rd_cand;
    logic              unused_prot;

    assign unused_prot = ^{axi.awprot, axi.arprot};
    assign w_beat_in   = '{strb: axi.wstrb, data: axi.wdata};

    axi4l_hold_slot #(.WIDTH(ADDR_W)) u_aw_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (axi.awvalid),
        .payload_i (axi.awaddr),
        .clear_i   (aw_clr),
        .ready_o   (axi.awready),
        .full_o    (aw_full),
        .payload_o (aw_addr)
    );

    axi4l_hold_slot #(.WIDTH($bits(w_beat_t))) u_w_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (axi.wvalid),
        .payload_i (w_beat_in),
        .clear_i   (w_clr),
        .ready_o   (axi.wready),
        .full_o    (w_full),
        .payload_o (w_beat)
    );

    axi4l_hold_slot #(.WIDTH(ADDR_W)) u_ar_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (axi.arvalid),
        .payload_i (axi.araddr),
        .clear_i   (ar_clr),
        .ready_o   (axi.arready),
        .full_o    (ar_full),
        .payload_o (ar_addr)
    );

    // Slots are released on the grant so the master can refill them while we wait.
    assign grant_fire = (state_q == S_REQ) && mem.gnt;
    assign aw_clr     = grant_fire && is_write_q;
    assign w_clr      = grant_fire && is_write_q;
    assign ar_clr     = grant_fire && !is_write_q;

    assign wr_cand = aw_full && w_full;
    assign rd_cand = ar_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_cand && (WRITE_FIRST || !rd_cand)) begin
                        is_write_q <= 1'b1;
                        req_q      <= 1'b1;
                        state_q    <= S_REQ;
                    end else if (rd_cand) begin
                        is_write_q <= 1'b0;
                        req_q      <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem.gnt) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem.rvalid) begin
                        if (!is_write_q) begin
                            rdata_q <= mem.rdata;
                        end
                        err_q    <= mem.err;
                        bvalid_q <= is_write_q;
                        rvalid_q <= !is_write_q;
                        state_q  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if ((bvalid_q && axi.bready) || (rvalid_q && axi.rready)) begin
                        bvalid_q <= 1'b0;
                        rvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Request fields come straight from the slots, which cannot change until the grant.
    assign mem.req   = req_q && rst_n;
    assign mem.we    = is_write_q;
    assign mem.addr  = is_write_q ? aw_addr : ar_addr;
    assign mem.be    = is_write_q ? w_beat.strb : {STRB_W{1'b1}};
    assign mem.wdata = is_write_q ? w_beat.data : '0;

    assign axi.bvalid = bvalid_q && rst_n;
    assign axi.bresp  = resp_from_err(err_q);
    assign axi.rvalid = rvalid_q && rst_n;
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = resp_from_err(err_q);

endmodule

// File: tb/tb_axi4l2core.sv
// Randomized and directed checks of the AXI4-Lite bridge against a word-array
// memory model and the protocol timing rules.
module tb_axi4l2core;
    import axi4l_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi4l_if    axi ();
    core_mem_if mem ();
    axi4l_if    axi_b ();
    core_mem_if mem_b ();

    axi4l2core #(.WRITE_FIRST(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (axi),
        .mem   (mem)
    );

    axi4l2core #(.WRITE_FIRST(1'b0)) dut_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (axi_b),
        .mem   (mem_b)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          txn_id   = 0;
    logic [31:0] ref_mem [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        axi.awvalid = 0; axi.awaddr = '0; axi.awprot = '0;
        axi.wvalid  = 0; axi.wdata  = '0; axi.wstrb  = '0;
        axi.arvalid = 0; axi.araddr = '0; axi.arprot = '0;
        axi.bready  = 0; axi.rready = 0;
        mem.gnt = 0; mem.rvalid = 0; mem.rdata = '0; mem.err = 0;
        axi_b.awvalid = 0; axi_b.awaddr = '0; axi_b.awprot = '0;
        axi_b.wvalid  = 0; axi_b.wdata  = '0; axi_b.wstrb  = '0;
        axi_b.arvalid = 0; axi_b.araddr = '0; axi_b.arprot = '0;
        axi_b.bready  = 0; axi_b.rready = 0;
        mem_b.gnt = 0; mem_b.rvalid = 0; mem_b.rdata = '0; mem_b.err = 0;
    endtask

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Drives the memory side and the response handshake from the first cycle after
    // the final address/data handshake until the AXI response is consumed.
    task automatic finish_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                              input logic err, input logic [31:0] rdata_ret, input int rdy_dly);
        logic [31:0] exp_resp;
        exp_resp = err ? 32'(RESP_SLVERR) : 32'(RESP_OKAY);
        chk("req_early", 32'(mem.req), 32'd0);
        step();
        for (int i = 0; i <= gnt_dly; i++) begin
            chk("req_high", 32'(mem.req), 32'd1);
            chk("req_we", 32'(mem.we), 32'(we));
            chk("req_addr", mem.addr, addr);
            chk("req_be", 32'(mem.be), 32'(be));
            chk("req_wdata", mem.wdata, wdata);
            mem.gnt    = (i == gnt_dly);
            mem.rvalid = 1'($urandom_range(0, 1));
            mem.err    = 1'b1;
            mem.rdata  = 32'hBAD0_0000 | 32'(i);
            step();
        end
        mem.gnt = 0; mem.rvalid = 0; mem.err = 0;
        chk("req_drop", 32'(mem.req), 32'd0);
        chk("slot_refill_rdy", 32'(we ? axi.awready : axi.arready), 32'd1);
        for (int i = 0; i < rv_dly; i++) begin
            chk("resp_early", 32'(axi.bvalid | axi.rvalid), 32'd0);
            step();
        end
        mem.rvalid = 1; mem.rdata = rdata_ret; mem.err = err;
        step();
        mem.rvalid = 0; mem.err = 0; mem.rdata = $urandom;
        for (int i = 0; i <= rdy_dly; i++) begin
            if (we) begin
                chk("bvalid", 32'(axi.bvalid), 32'd1);
                chk("bresp", 32'(axi.bresp), exp_resp);
                chk("no_rvalid", 32'(axi.rvalid), 32'd0);
                axi.bready = (i == rdy_dly);
            end else begin
                chk("rvalid", 32'(axi.rvalid), 32'd1);
                chk("rdata", axi.rdata, rdata_ret);
                chk("rresp", 32'(axi.rresp), exp_resp);
                chk("no_bvalid", 32'(axi.bvalid), 32'd0);
                axi.rready = (i == rdy_dly);
            end
            step();
        end
        axi.bready = 0; axi.rready = 0;
        chk("resp_done", 32'(axi.bvalid | axi.rvalid), 32'd0);
        $display("txn %0d %s addr=0x%08h data=0x%08h be=%h err=%0d gnt_dly=%0d",
                 txn_id, we ? "WR" : "RD", addr, we ? wdata : rdata_ret, be, err, gnt_dly);
        txn_id++;
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first, with gap idle cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int order, input int gap, input int gnt_dly, input int rv_dly,
                            input logic err, input int rdy_dly);
        chk("awready_idle", 32'(axi.awready), 32'd1);
        chk("wready_idle", 32'(axi.wready), 32'd1);
        if (order == 0) begin
            axi.awvalid = 1; axi.awaddr = addr;
            axi.wvalid = 1; axi.wdata = data; axi.wstrb = strb;
            step();
            axi.awvalid = 0; axi.wvalid = 0; axi.awaddr = $urandom; axi.wdata = $urandom;
        end else if (order == 1) begin
            axi.awvalid = 1; axi.awaddr = addr;
            step();
            axi.awvalid = 0; axi.awaddr = $urandom;
            for (int i = 0; i < gap; i++) begin
                chk("awready_full", 32'(axi.awready), 32'd0);
                chk("lone_aw_noreq", 32'(mem.req), 32'd0);
                step();
            end
            axi.wvalid = 1; axi.wdata = data; axi.wstrb = strb;
            step();
            axi.wvalid = 0; axi.wdata = $urandom;
        end else begin
            axi.wvalid = 1; axi.wdata = data; axi.wstrb = strb;
            step();
            axi.wvalid = 0; axi.wdata = $urandom; axi.wstrb = 4'($urandom);
            for (int i = 0; i < gap; i++) begin
                chk("wready_full", 32'(axi.wready), 32'd0);
                chk("lone_w_noreq", 32'(mem.req), 32'd0);
                step();
            end
            axi.awvalid = 1; axi.awaddr = addr;
            step();
            axi.awvalid = 0; axi.awaddr = $urandom;
        end
        finish_txn(1'b1, addr, strb, data, gnt_dly, rv_dly, err, $urandom, rdy_dly);
        if (!err) ref_mem[addr[5:2]] = apply_strb(ref_mem[addr[5:2]], data, strb);
    endtask

    task automatic do_read(input logic [31:0] addr, input int gnt_dly, input int rv_dly,
                           input logic err, input int rdy_dly, input logic [31:0] rdata_ret);
        chk("arready_idle", 32'(axi.arready), 32'd1);
        axi.arvalid = 1; axi.araddr = addr;
        step();
        axi.arvalid = 0; axi.araddr = $urandom;
        finish_txn(1'b0, addr, 4'hF, 32'd0, gnt_dly, rv_dly, err, rdata_ret, rdy_dly);
    endtask

    initial begin
        logic        q_we [$];
        logic [31:0] a;
        logic [31:0] d;

        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        idle_inputs();
        rst_n = 0;
        repeat (3) step();
        chk("rst_awready", 32'(axi.awready), 32'd0);
        chk("rst_wready", 32'(axi.wready), 32'd0);
        chk("rst_arready", 32'(axi.arready), 32'd0);
        chk("rst_req", 32'(mem.req), 32'd0);
        chk("rst_valids", 32'(axi.bvalid | axi.rvalid), 32'd0);
        rst_n = 1;
        step();
        chk("post_rst_readies", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);
        chk("post_rst_req", 32'(mem.req), 32'd0);

        // Directed scenarios
        do_write(32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1, 1'b0, 0);
        do_write(32'h20, 32'hCAFEF00D, 4'hF, 2, 3, 0, 0, 1'b0, 0);
        do_read(32'h40, 5, 0, 1'b0, 0, 32'h12345678);
        do_read(32'h44, 1, 2, 1'b1, 4, ref_mem[1]);
        do_write(32'h48, 32'h0BADCAFE, 4'h5, 1, 2, 2, 1, 1'b1, 4);

        // Randomized traffic against the word-array model
        for (int t = 0; t < 24; t++) begin
            a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                         $urandom_range(0, 4), $urandom_range(0, 3),
                         ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 4), $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0), $urandom_range(0, 3), ref_mem[a[5:2]]);
        end

        // Reset while waiting for the memory response
        axi.arvalid = 1; axi.araddr = 32'h8;
        step();
        axi.arvalid = 0;
        step();
        mem.gnt = 1;
        step();
        mem.gnt = 0;
        axi.awvalid = 1; axi.awaddr = 32'h3C;
        step();
        axi.awvalid = 0;
        rst_n = 0; mem.rvalid = 1; mem.rdata = 32'h55AA55AA;
        step();
        chk("midrst_readies", 32'({axi.awready, axi.wready, axi.arready}), 32'h0);
        chk("midrst_req", 32'(mem.req), 32'd0);
        chk("midrst_valids", 32'(axi.bvalid | axi.rvalid), 32'd0);
        rst_n = 1; mem.rvalid = 0;
        step();
        chk("midrst_after_readies", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);
        chk("midrst_after_valids", 32'(axi.bvalid | axi.rvalid), 32'd0);
        d = 32'h600DD00D;
        axi.wvalid = 1; axi.wdata = d; axi.wstrb = 4'hF;
        step();
        axi.wvalid = 0;
        step();
        step();
        chk("midrst_aw_flushed", 32'(mem.req), 32'd0);
        axi.awvalid = 1; axi.awaddr = 32'h30;
        step();
        axi.awvalid = 0;
        finish_txn(1'b1, 32'h30, 4'hF, d, 0, 0, 1'b0, 32'd0, 0);
        ref_mem[12] = d;

        // Arbitration: AR and a complete write pending together in IDLE
        axi.awvalid = 1; axi.awaddr = 32'h4; axi.wvalid = 1; axi.wdata = 32'h1; axi.wstrb = 4'hF;
        axi.arvalid = 1; axi.araddr = 32'h8;
        axi_b.awvalid = 1; axi_b.awaddr = 32'h4; axi_b.wvalid = 1; axi_b.wdata = 32'h1;
        axi_b.wstrb = 4'hF; axi_b.arvalid = 1; axi_b.araddr = 32'h8;
        step();
        axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0;
        axi_b.awvalid = 0; axi_b.wvalid = 0; axi_b.arvalid = 0;
        mem.gnt = 1; mem.rvalid = 1; axi.bready = 1; axi.rready = 1;
        for (int i = 0; i < 16; i++) begin
            if (mem.req) q_we.push_back(mem.we);
            step();
        end
        mem.gnt = 0; mem.rvalid = 0; axi.bready = 0; axi.rready = 0;
        chk("wf1_count", 32'(q_we.size()), 32'd2);
        chk("wf1_first_we", 32'(q_we[0]), 32'd1);
        chk("wf1_second_we", 32'(q_we[1]), 32'd0);
        $display("txn %0d ARB write_first=1 order=%s", txn_id, (q_we[0] === 1'b1) ? "WR,RD" : "RD,WR");
        txn_id++;

        q_we.delete();
        mem_b.gnt = 1; mem_b.rvalid = 1; axi_b.bready = 1; axi_b.rready = 1;
        for (int i = 0; i < 16; i++) begin
            if (mem_b.req) q_we.push_back(mem_b.we);
            step();
        end
        mem_b.gnt = 0; mem_b.rvalid = 0; axi_b.bready = 0; axi_b.rready = 0;
        chk("wf0_count", 32'(q_we.size()), 32'd2);
        chk("wf0_first_we", 32'(q_we[0]), 32'd0);
        chk("wf0_second_we", 32'(q_we[1]), 32'd1);
        $display("txn %0d ARB write_first=0 order=%s", txn_id, (q_we[0] === 1'b0) ? "RD,WR" : "WR,RD");
        txn_id++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4l2core.md
AXI4L2CORE -- requirements
Module: axi4l2core

Interface
REQ-001 Parameter WRITE_FIRST, default 1'b1: when 1, a complete write wins over a pending read in IDLE; when 0, the read wins.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 axi.awvalid/awaddr/awprot  input  1/32/3, axi.awready  output  1  write-address channel; awprot ignored.
REQ-006 axi.wvalid/wdata/wstrb  input  1/32/4, axi.wready  output  1  write-data channel.
REQ-007 axi.bvalid/bresp  output  1/2, axi.bready  input  1  write-response channel.
REQ-008 axi.arvalid/araddr/arprot  input  1/32/3, axi.arready  output  1  read-address channel; arprot ignored.
REQ-009 axi.rvalid/rdata/rresp  output  1/32/2, axi.rready  input  1  read-data channel.
REQ-010 mem.req/we/be/addr/wdata  output  1/1/4/32/32  core-style request to the memory side.
REQ-011 mem.gnt/rvalid/rdata/err  input  1/1/32/1  core-style grant, response, read data, error.

Function
REQ-012 Three independent one-entry holding slots (AW, W, AR); awready = !aw_full, wready = !w_full, arready = !ar_full, all forced 0 while rst_n is low.
REQ-013 A slot loads its payload and sets its full flag on its valid&&ready cycle; AW and W are accepted in either order or in the same cycle.
REQ-014 FSM states: IDLE, REQ, WAIT, RESP; a single transaction is outstanding at any time.
REQ-015 IDLE: write candidate = aw_full&&w_full, read candidate = ar_full; if both, WRITE_FIRST selects; selected op is latched into is_write; next state REQ; no candidate -> stay IDLE.
REQ-016 REQ: mem.req=1; we=is_write; addr=awaddr or araddr slot; wdata/be=W slot when writing, be=4'hF and wdata=0 when reading; all held stable until mem.gnt.
REQ-017 REQ with mem.gnt=1: clear the used slot(s) (AW+W or AR) in that cycle, go WAIT; mem.gnt=0 -> stay REQ.
REQ-018 mem.rvalid is sampled only in WAIT; mem.rvalid in REQ or IDLE is ignored.
REQ-019 WAIT with mem.rvalid=1: register rdata (reads only) and err, go RESP.
REQ-020 RESP, write: bvalid=1, bresp = err ? SLVERR(2'b10) : OKAY(2'b00); on bready go IDLE.
REQ-021 RESP, read: rvalid=1, rdata=registered data, rresp as REQ-020; on rready go IDLE.
REQ-022 bvalid/rvalid and their payloads SHALL stay stable until the handshake.
REQ-023 Latency: AW/W (or AR) handshake in cycle N -> mem.req first high in cycle N+2; mem.rvalid in cycle M -> bvalid/rvalid high in cycle M+1.
REQ-024 Slots may refill during REQ/WAIT/RESP once cleared; refilled slots are served only after return to IDLE.
REQ-025 A lone AW or lone W never issues a mem request; it waits indefinitely for its partner.

Reset
REQ-026 rst_n low: state=IDLE, all full flags=0, is_write=0, response registers=0.
REQ-027 During and one cycle after reset: mem.req=0, bvalid=0, rvalid=0, all readies=0 during reset and 1 in the first cycle after.
REQ-028 Reset mid-transaction SHALL abandon it without any response; the memory side is reset concurrently.

Structure
REQ-029 Response encodings (OKAY, SLVERR) come from axi4l_pkg; the FSM enum stays local.
REQ-030 One sub-module, axi4l_hold_slot (parameterised payload width, valid/ready in, full/payload out, clear input), is instantiated for AW, W, and AR.

Verification
REQ-031 AW(0x100) and W(0xDEADBEEF, 4'hF) in the same cycle, gnt immediate, rvalid after 1 cycle -> mem write addr 0x100, bvalid with bresp=OKAY.
REQ-032 W three cycles before AW(0x20) -> wready low after W, no mem.req until AW arrives, then write to 0x20.
REQ-033 AR(0x40), gnt delayed 5 cycles, mem.rdata=0x12345678 -> req stable for 6 cycles, rdata=0x12345678, rresp=OKAY.
REQ-034 AR and complete AW/W pending together in IDLE, WRITE_FIRST=1 -> write issued first, then read; WRITE_FIRST=0 -> read first.
REQ-035 mem.err=1 on a read and on a write; rready/bready held low for 4 cycles -> rresp and bresp=SLVERR held stable until ready.
REQ-036 rst_n asserted while in WAIT -> next cycle state=IDLE, no bvalid/rvalid, slots empty.
